// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-state REQ/VALID fetch FSM with redirect priority.
// Optional FETCH_ILLEGAL_OP_EN adds an unsupported-opcode flag on the held instruction.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic        illegal_op
);

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        handshake;

  assign handshake = (state_q == S_VALID) && instr_ready;

  // Redirect wins over everything: drops any ack in flight and any held instruction.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (redirect) begin
      state_d = S_REQ;
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
    end else if (state_q == S_REQ) begin
      if (imem_ack) begin
        state_d = S_VALID;
        instr_d = imem_rdata;
      end
    end else if (handshake) begin
      state_d = S_REQ;
      pc_d    = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Request is held off while reset is asserted so the first fetch follows release.
  assign imem_req    = (state_q == S_REQ) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign op          = instr_q[6:0];

`ifdef FETCH_ILLEGAL_OP_EN
  always_comb begin
    illegal_op = 1'b0;
    case (op)
      7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011: illegal_op = 1'b0;
      default:                                        illegal_op = instr_valid;
    endcase
  end
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: acked words are queued and checked at handshake.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_pc;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic exp_illegal(input logic [6:0] o);
`ifdef FETCH_ILLEGAL_OP_EN
    return !(o inside {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011});
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_req();
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Called at a negedge while the DUT holds a valid instruction; pops and checks it.
  task automatic consume();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("instr", instr, e.ins);
      chk("pc", pc, e.pc);
      chk("op", {25'd0, op}, {25'd0, e.ins[6:0]});
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, exp_illegal(e.ins[6:0])});
    end
    instr_ready = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] data, input int hold);
    wait_req();
    chk("imem_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = data;
    sb.push_back('{pc: exp_pc, ins: data});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("req_in_valid", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", instr, sb[0].ins);
      chk("hold_pc", pc, sb[0].pc);
    end
    consume();
    exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("req_after_hs", {31'd0, imem_req}, 32'd1);
    chk("valid_after_hs", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);

    // Back-to-back sequential fetches with immediate ack and ready.
    exp_pc = 32'h0;
    fetch(32'h0000_0033, 0);
    fetch(32'h0041_2083, 0);
    fetch(32'h0011_2223, 0);
    fetch(32'h0020_8463, 0);
    // Downstream stall for five cycles.
    fetch(32'h0020_81B3, 5);

    // Ready while nothing is valid must not disturb the request.
    wait_req();
    instr_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_ready_req", {31'd0, imem_req}, 32'd1);
      chk("idle_ready_valid", {31'd0, instr_valid}, 32'd0);
      chk("idle_ready_addr", imem_addr, exp_pc);
    end
    instr_ready = 1'b0;

    // Redirect coinciding with an ack drops the returned data.
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_instr_kept", instr, 32'h0020_81B3);
    exp_pc = 32'h0000_0100;

    fetch(32'h0000_0013, 0);
    fetch(32'h0000_0063, 0);

    // Redirect together with a handshake: consumed, pc takes the target.
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0033;
    sb.push_back('{pc: exp_pc, ins: 32'h0000_0033});
    @(negedge clk);
    imem_ack = 1'b0;
    consume();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0; instr_ready = 1'b0;
    chk("hs_redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("hs_redir_pc", pc, 32'h0000_0200);
    chk("hs_redir_sb", sb.size(), 32'd0);

    // Wrap of pc+4 at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect = 1'b0;
    chk("wrap_start", imem_addr, 32'hFFFF_FFFC);
    exp_pc = 32'hFFFF_FFFC;
    fetch(32'h0000_0033, 0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of an outstanding fetch.
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect = 1'b0;
    chk("pre_rst_addr", imem_addr, 32'h0000_0040);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0063;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_instr", instr, 32'h0);
    @(negedge clk);
    chk("ack_in_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("ack_in_rst_instr", instr, 32'h0);
    imem_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    exp_pc = 32'h0;
    fetch(32'h0000_0023, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset; bits [1:0] SHALL be treated as 0.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  instruction memory byte address; always equals pc.
REQ-006 imem_ack  input  1  memory response valid; meaningful only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-008 redirect  input  1  branch/jump taken; forces a new PC.
REQ-009 redirect_pc  input  32  target address for redirect.
REQ-010 instr_valid  output  1  instr holds a fetched instruction for downstream.
REQ-011 instr_ready  input  1  downstream accepts instr this cycle.
REQ-012 instr  output  32  fetched instruction word (registered).
REQ-013 op  output  7  instr[6:0], combinational; drives the control unit op input.
REQ-014 pc  output  32  address of the instruction in instr / currently requested.
REQ-015 illegal_op  output  1  opcode outside the supported set (see Configuration).

Function
REQ-016 FSM states: REQ (fetch outstanding) and VALID (instruction held); no other states.
REQ-017 In REQ: imem_req=1, instr_valid=0, imem_addr=pc held stable until imem_ack.
REQ-018 REQ, imem_ack=1, redirect=0: instr<=imem_rdata, state->VALID, instr_valid=1 on the next cycle.
REQ-019 REQ, imem_ack=0: remain in REQ, no register change.
REQ-020 In VALID: imem_req=0, instr_valid=1, instr and pc stable until handshake.
REQ-021 Handshake = instr_valid & instr_ready at a rising edge; on handshake with redirect=0, pc<=pc+4 and state->REQ.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 redirect=1 in any state has priority: pc<={redirect_pc[31:2],2'b00}, state->REQ, instr_valid=0 next cycle; any imem_ack in that cycle and any held instr are discarded; instr register value unchanged.
REQ-024 Redirect simultaneous with handshake: handshake counts as consumed, pc takes redirect target, not pc+4.
REQ-025 Latency: imem_ack in cycle N -> instr_valid=1 in cycle N+1; maximum throughput 1 instruction per 2 cycles.
REQ-026 instr_ready while instr_valid=0 SHALL have no effect.
REQ-027 op SHALL always equal instr[6:0], independent of instr_valid.

Reset
REQ-028 rst=1 SHALL immediately, without clock: pc=RESET_PC, instr=32'h0000_0000, state=REQ, instr_valid=0, illegal_op=0.
REQ-029 While rst=1: imem_req=0; first request asserted in the first cycle after rst deasserts, at address RESET_PC.
REQ-030 Reset asserted mid-fetch SHALL abandon the outstanding request; an imem_ack during reset is ignored.

Configuration
REQ-031 Macro FETCH_ILLEGAL_OP_EN: when defined, illegal_op = instr_valid & (op not in {7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011}); instruction is still presented normally.
REQ-032 Without FETCH_ILLEGAL_OP_EN, illegal_op SHALL be constant 0 and no check logic synthesised.

Verification
REQ-033 Reset release, RESET_PC=0, ack next cycle with rdata=32'h0000_0033 -> imem_addr=0, then instr_valid=1, op=7'b0110011, pc=0.
REQ-034 Four sequential fetches, instr_ready=1, ack same cycle as req -> imem_addr 0,4,8,12; one instr_valid pulse every 2 cycles.
REQ-035 instr_ready=0 for 5 cycles in VALID -> instr, pc, instr_valid stable, imem_req=0; ready=1 -> next req at pc+4.
REQ-036 redirect=1, redirect_pc=32'h0000_0102, during REQ with imem_ack=1 -> data dropped, next imem_addr=32'h0000_0100, instr_valid=0.
REQ-037 pc=32'hFFFF_FFFC, handshake -> next imem_addr=32'h0000_0000.
REQ-038 With FETCH_ILLEGAL_OP_EN, rdata=32'h0000_0013 -> illegal_op=1 while valid; rdata=32'h0000_0063 -> illegal_op=0; without macro illegal_op=0 for both.
